// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART-to-APB bridge: opcodes, frame field positions,
// master FSM states and the response-frame packer.
package uart_apb_pkg;

    localparam int unsigned FRAME_W = 56;
    localparam int unsigned CMD_HI  = 55;
    localparam int unsigned CMD_LO  = 48;
    localparam int unsigned ADDR_HI = 47;
    localparam int unsigned ADDR_LO = 32;
    localparam int unsigned DATA_HI = 31;
    localparam int unsigned DATA_LO = 0;

    localparam logic [7:0] OPC_WREQ = 8'h02;
    localparam logic [7:0] OPC_RREQ = 8'h03;
    localparam logic [7:0] OPC_RESP = 8'h04;
    localparam logic [7:0] OPC_ERR  = 8'h0E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP,
        ST_TXWAIT,
        ST_TXDONE
    } state_t;

    function automatic logic [FRAME_W-1:0] mk_frame(input logic [7:0]  cmd,
                                                    input logic [15:0] addr,
                                                    input logic [31:0] data);
        return {cmd, addr, data};
    endfunction

endpackage

// File: rtl/apb_master_ctrl.sv
// Bridge core: turns one UART request frame into a single APB3 transfer and
// hands the response frame to UART TX, refusing new frames until TX has drained it.
module apb_master_ctrl
    import uart_apb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [7:0]  CMD_WREQ = OPC_WREQ,
    parameter logic [7:0]  CMD_RREQ = OPC_RREQ,
    parameter logic [7:0]  CMD_RESP = OPC_RESP,
    parameter logic [7:0]  CMD_ERR  = OPC_ERR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_vld,
    output logic               full_to_rx,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [ADDR_W-1:0]  paddr,
    output logic [DATA_W-1:0]  pwdata,
    input  logic [DATA_W-1:0]  prdata,
    input  logic               pready,
    input  logic               pslverr,
    output logic [FRAME_W-1:0] pres,
    output logic               data_vld_tx,
    input  logic               busy,
    output logic               drop_err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FRAME_W-1:0] r_frame;
    logic [FRAME_W-1:0] r_pres;
    logic [FRAME_W-1:0] w_pres_nxt;
    logic               r_vld_tx;
    logic               w_vld_tx_nxt;
    logic [TMO_W-1:0]   r_tmo;
    logic [TMO_W-1:0]   w_tmo_nxt;
    logic               r_drop;

    logic [7:0]         w_in_cmd;
    logic [15:0]        w_in_addr;
    logic [7:0]         w_cmd;
    logic [15:0]        w_addr;
    logic [31:0]        w_data;
    logic               w_is_wr;
    logic               w_apb_act;
    logic               w_full;

    assign w_in_cmd  = frame_in[CMD_HI:CMD_LO];
    assign w_in_addr = frame_in[ADDR_HI:ADDR_LO];
    assign w_cmd     = r_frame[CMD_HI:CMD_LO];
    assign w_addr    = r_frame[ADDR_HI:ADDR_LO];
    assign w_data    = r_frame[DATA_HI:DATA_LO];
    assign w_is_wr   = (w_cmd == CMD_WREQ);
    assign w_apb_act = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign w_full    = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt  = r_state;
        w_pres_nxt   = r_pres;
        w_vld_tx_nxt = 1'b0;
        w_tmo_nxt    = r_tmo;
        case (r_state)
            ST_IDLE: begin
                if (frame_vld) begin
                    if (w_in_cmd == CMD_WREQ || w_in_cmd == CMD_RREQ) begin
                        w_state_nxt = ST_SETUP;
                    end else begin
                        w_state_nxt = ST_RESP;
                        w_pres_nxt  = mk_frame(CMD_ERR, w_in_addr, 32'h0);
                    end
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
                w_tmo_nxt   = '0;
            end
            ST_ACCESS: begin
                // pslverr and prdata only mean something on the pready cycle
                if (pready) begin
                    w_state_nxt = ST_RESP;
                    w_tmo_nxt   = '0;
                    if (pslverr)
                        w_pres_nxt = mk_frame(CMD_ERR, w_addr, 32'h0);
                    else if (w_is_wr)
                        w_pres_nxt = mk_frame(CMD_RESP, w_addr, w_data);
                    else
                        w_pres_nxt = mk_frame(CMD_RESP, w_addr, 32'(prdata));
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nxt = ST_RESP;
                    w_tmo_nxt   = '0;
                    w_pres_nxt  = mk_frame(CMD_ERR, w_addr, 32'hFFFF_FFFF);
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            ST_RESP: begin
                if (!busy) begin
                    w_vld_tx_nxt = 1'b1;
                    w_state_nxt  = ST_TXWAIT;
                end
            end
            ST_TXWAIT: begin
                if (busy) w_state_nxt = ST_TXDONE;
            end
            ST_TXDONE: begin
                if (!busy) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_pres   <= '0;
            r_vld_tx <= 1'b0;
            r_tmo    <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pres   <= w_pres_nxt;
            r_vld_tx <= w_vld_tx_nxt;
            r_tmo    <= w_tmo_nxt;
            r_drop   <= r_drop | (frame_vld & w_full);
        end
    end

    // Request frame is only ever read while the FSM is out of IDLE, so it needs no reset
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && frame_vld) r_frame <= frame_in;
    end

    assign full_to_rx  = w_full;
    assign psel        = w_apb_act;
    assign penable     = (r_state == ST_ACCESS);
    assign pwrite      = w_apb_act & w_is_wr;
    assign paddr       = w_apb_act ? ADDR_W'(w_addr) : '0;
    assign pwdata      = (w_apb_act && w_is_wr) ? DATA_W'(w_data) : '0;
    assign pres        = r_pres;
    assign data_vld_tx = r_vld_tx;
    assign drop_err    = r_drop;

endmodule
